// File: rtl/spi_frame_receiver_if.sv
// spi_frame_receiver_if
// Groups the SPI pins and the frame-delivery handshake of spi_frame_receiver.
//   spi_clock  SPI clock from master, idles high
//   spi_data   serial data, MSB first
//   cs_n       chip select, active-low
//   rx_data    head-of-FIFO frame word
//   rx_valid   FIFO non-empty
//   rx_ready   consumer accepts head word
//   frame_err  one-cycle pulse: frame discarded for wrong length
//   overflow   one-cycle pulse: valid frame dropped, FIFO full
//   busy       frame reception in progress
// Modports: slave = receiver side, master = SPI master / consumer side.
interface spi_frame_receiver_if #(
  parameter int unsigned FRAME_BITS = 24
);
  logic                  spi_clock;
  logic                  spi_data;
  logic                  cs_n;
  logic [FRAME_BITS-1:0] rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic                  frame_err;
  logic                  overflow;
  logic                  busy;

  modport slave (
    input  spi_clock, spi_data, cs_n, rx_ready,
    output rx_data, rx_valid, frame_err, overflow, busy
  );

  modport master (
    output spi_clock, spi_data, cs_n, rx_ready,
    input  rx_data, rx_valid, frame_err, overflow, busy
  );
endinterface

// File: rtl/spi_frame_receiver.sv
// spi_frame_receiver
// Oversampling SPI receive endpoint (clock idles high, sampled on rising edge)
// for the 24-bit command link. Completed frames are validated and queued in a
// small FIFO, then delivered over a valid/ready handshake.
// Ports:
//   clk    system clock (>= 8x spi_clock)
//   rst_n  asynchronous active-low reset
//   bus    spi_frame_receiver_if.slave (SPI pins, rx handshake, status pulses)
// Optional feature macro: SPI_RX_LENGTH_CHECK_EN
//   defined   : frames whose bit count is neither 0 nor FRAME_BITS are dropped
//               and frame_err pulses
//   undefined : any non-empty frame is queued (short frames zero-extended,
//               long frames keep their last FRAME_BITS bits), frame_err is 0
module spi_frame_receiver #(
  parameter int unsigned FRAME_BITS  = 24,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned FIFO_DEPTH  = 4
) (
  input logic                 clk,
  input logic                 rst_n,
  spi_frame_receiver_if.slave bus
);
  localparam int unsigned CNT_W = $clog2(FRAME_BITS + 2);
  localparam int unsigned AW    = $clog2(FIFO_DEPTH);
  localparam int unsigned PW    = AW + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, COMMIT} state_t;

  state_t                 state, state_n;
  logic [SYNC_STAGES-1:0] sclk_sync, data_sync, cs_sync;
  logic                   sclk_hist, cs_hist;
  logic                   sclk_s, data_s, cs_s;
  logic                   sclk_rise, cs_rise;

  logic [FRAME_BITS-1:0]  shreg;
  logic [CNT_W-1:0]       bit_cnt;
  logic                   clr_c, shift_c, push_c, frame_err_c, overflow_c;
  logic                   do_push, pop, full;

  logic [FRAME_BITS-1:0]  mem [FIFO_DEPTH];
  logic [PW-1:0]          wptr, rptr, wptr_n, rptr_n;
  logic [FRAME_BITS-1:0]  head_n;

  logic [FRAME_BITS-1:0]  rx_data_q;
  logic                   rx_valid_q, frame_err_q, overflow_q, busy_q;

  // Input synchronizers; reset to idle levels so no edge is seen at release
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sclk_sync <= '1;
      data_sync <= '1;
      cs_sync   <= '1;
      sclk_hist <= 1'b1;
      cs_hist   <= 1'b1;
    end else begin
      sclk_sync <= {sclk_sync[SYNC_STAGES-2:0], bus.spi_clock};
      data_sync <= {data_sync[SYNC_STAGES-2:0], bus.spi_data};
      cs_sync   <= {cs_sync[SYNC_STAGES-2:0], bus.cs_n};
      sclk_hist <= sclk_s;
      cs_hist   <= cs_s;
    end
  end

  assign sclk_s    = sclk_sync[SYNC_STAGES-1];
  assign data_s    = data_sync[SYNC_STAGES-1];
  assign cs_s      = cs_sync[SYNC_STAGES-1];
  assign sclk_rise = sclk_s & ~sclk_hist;
  assign cs_rise   = cs_s & ~cs_hist;

  // FSM state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  // Next state and frame evaluation
  always_comb begin
    state_n     = state;
    clr_c       = 1'b0;
    shift_c     = 1'b0;
    push_c      = 1'b0;
    frame_err_c = 1'b0;
    case (state)
      IDLE: begin
        if (!cs_s) begin
          clr_c   = 1'b1;
          state_n = SHIFT;
        end
      end
      SHIFT: begin
        if (cs_rise)                state_n = COMMIT;
        else if (sclk_rise && !cs_s) shift_c = 1'b1;
      end
      COMMIT: begin
        state_n = IDLE;
        if (bit_cnt == CNT_W'(FRAME_BITS)) begin
          push_c = 1'b1;
        end else if (bit_cnt != '0) begin
`ifdef SPI_RX_LENGTH_CHECK_EN
          frame_err_c = 1'b1;
`else
          push_c = 1'b1;
`endif
        end
      end
      default: state_n = IDLE;
    endcase
  end

  // Shift register and saturating bit counter
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (clr_c) begin
      shreg   <= '0;
      bit_cnt <= '0;
    end else if (shift_c) begin
      shreg <= {shreg[FRAME_BITS-2:0], data_s};
      if (bit_cnt != CNT_W'(FRAME_BITS + 1)) bit_cnt <= bit_cnt + CNT_W'(1);
    end
  end

  // FIFO control; a pop frees the slot a same-cycle push needs when full
  assign full       = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign pop        = rx_valid_q && bus.rx_ready;
  assign overflow_c = push_c && full && !pop;
  assign do_push    = push_c && !overflow_c;
  assign wptr_n     = wptr + PW'(do_push);
  assign rptr_n     = rptr + PW'(pop);

  // Head after this cycle: the incoming word if it lands at the new read slot
  always_comb begin
    head_n = mem[rptr_n[AW-1:0]];
    if (do_push && (rptr_n == wptr)) head_n = shreg;
  end

  always_ff @(posedge clk) begin
    if (do_push) mem[wptr[AW-1:0]] <= shreg;
  end

  // Pointers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wptr        <= '0;
      rptr        <= '0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overflow_q  <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      wptr        <= wptr_n;
      rptr        <= rptr_n;
      rx_data_q   <= head_n;
      rx_valid_q  <= (wptr_n != rptr_n);
      frame_err_q <= frame_err_c;
      overflow_q  <= overflow_c;
      busy_q      <= ~cs_s;
    end
  end

  assign bus.rx_data   = rx_data_q;
  assign bus.rx_valid  = rx_valid_q;
  assign bus.frame_err = frame_err_q;
  assign bus.overflow  = overflow_q;
  assign bus.busy      = busy_q;
endmodule

// File: tb/tb_spi_frame_receiver.sv
// tb_spi_frame_receiver
// Drives SPI frames (sclk = clk/10) into spi_frame_receiver and checks every
// cycle against a frame-level model: pin-level bit counting, a word queue of
// FIFO_DEPTH entries, and the documented commit/sync latencies. Directed
// scenarios add literal expectations. Honors SPI_RX_LENGTH_CHECK_EN.
module tb_spi_frame_receiver;
  localparam int unsigned FB    = 24;
  localparam int unsigned SS    = 2;
  localparam int unsigned DEPTH = 4;

  logic clk;
  logic rst_n;

  spi_frame_receiver_if #(.FRAME_BITS(FB)) bus ();

  spi_frame_receiver #(
    .FRAME_BITS (FB),
    .SYNC_STAGES(SS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- behavioural model ----------------
  logic [FB-1:0] mq[$];
  logic [FB-1:0] acc       = '0;
  int            nbits     = 0;
  logic          cs_prev   = 1'b1;
  logic          sclk_prev = 1'b1;
  int            cd        = 0;
  logic          csh[$];
  logic          exp_valid = 1'b0;
  logic [FB-1:0] exp_data  = '0;
  logic          exp_ferr  = 1'b0;
  logic          exp_ovf   = 1'b0;
  logic          exp_busy  = 1'b0;
  int            cyc       = 0;

  function automatic void commit_frame();
    logic push;
    push = 1'b0;
    if (nbits == int'(FB)) push = 1'b1;
    else if (nbits != 0) begin
`ifdef SPI_RX_LENGTH_CHECK_EN
      exp_ferr = 1'b1;
`else
      push = 1'b1;
`endif
    end
    if (push) begin
      if (mq.size() < int'(DEPTH)) mq.push_back(acc);
      else exp_ovf = 1'b1;
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      csh.delete();
      for (int i = 0; i < int'(SS); i++) csh.push_back(1'b1);
      acc = '0; nbits = 0; cs_prev = 1'b1; sclk_prev = 1'b1; cd = 0;
      exp_ferr = 1'b0; exp_ovf = 1'b0; exp_busy = 1'b0;
      exp_valid = 1'b0; exp_data = '0;
    end else begin
      cyc++;
      exp_ferr = 1'b0;
      exp_ovf  = 1'b0;
      if (mq.size() > 0 && bus.rx_ready) void'(mq.pop_front());
      if (cd > 0) begin
        cd--;
        if (cd == 0) commit_frame();
      end
      if (cs_prev && !bus.cs_n) begin acc = '0; nbits = 0; end
      if (!bus.cs_n && bus.spi_clock && !sclk_prev) begin
        acc = {acc[FB-2:0], bus.spi_data};
        nbits++;
      end
      if (!cs_prev && bus.cs_n) cd = int'(SS) + 1;
      cs_prev   = bus.cs_n;
      sclk_prev = bus.spi_clock;
      csh.push_back(bus.cs_n);
      exp_busy  = ~csh.pop_front();
      exp_valid = (mq.size() > 0);
      exp_data  = exp_valid ? mq[0] : '0;
    end
  end

  // ---------------- checking ----------------
  int            checks = 0;
  int            errors = 0;
  logic [FB-1:0] pop_log[$];
  int            pop_cyc[$];
  int            valid_cnt = 0;
  int            ferr_cnt  = 0;
  int            ovf_cnt   = 0;
  logic          prev_valid = 1'b0;
  logic [FB-1:0] prev_data  = '0;
  logic          rand_ready = 1'b0;
  int            t_cs = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(negedge clk);
      if (rand_ready) bus.rx_ready = 1'($urandom_range(0, 1));
    end
  endtask

  // Sends bits n-1..0 of val; optionally pulses reset after bit rst_at.
  task automatic send_frame(input logic [63:0] val, input int n, input int rst_at);
    bus.cs_n = 1'b0;
    tick(3);
    for (int i = n - 1; i >= 0; i--) begin
      bus.spi_clock = 1'b0;
      bus.spi_data  = val[i];
      tick(5);
      bus.spi_clock = 1'b1;
      if (rst_at > 0 && (n - i) == rst_at) begin
        tick(2);
        rst_n = 1'b0;
        #1;
        chk("rst_rx_valid", 64'(bus.rx_valid), 64'd0);
        chk("rst_rx_data", 64'(bus.rx_data), 64'd0);
        chk("rst_frame_err", 64'(bus.frame_err), 64'd0);
        chk("rst_overflow", 64'(bus.overflow), 64'd0);
        chk("rst_busy", 64'(bus.busy), 64'd0);
        tick(3);
        rst_n = 1'b1;
        tick(7);
      end else begin
        tick(5);
      end
    end
    bus.cs_n = 1'b1;
    t_cs = cyc;
  endtask

  int b, vb, fb, ob;

  initial begin
    rst_n         = 1'b0;
    bus.cs_n      = 1'b1;
    bus.spi_clock = 1'b1;
    bus.spi_data  = 1'b0;
    bus.rx_ready  = 1'b0;

    fork
      forever begin
        @(posedge clk);
        #1;
        if (rst_n && prev_valid && bus.rx_ready) begin
          pop_log.push_back(prev_data);
          pop_cyc.push_back(cyc - 1);
        end
        chk("rx_valid", 64'(bus.rx_valid), 64'(exp_valid));
        if (exp_valid) chk("rx_data", 64'(bus.rx_data), 64'(exp_data));
        chk("frame_err", 64'(bus.frame_err), 64'(exp_ferr));
        chk("overflow", 64'(bus.overflow), 64'(exp_ovf));
        chk("busy", 64'(bus.busy), 64'(exp_busy));
        if (bus.rx_valid)  valid_cnt++;
        if (bus.frame_err) ferr_cnt++;
        if (bus.overflow)  ovf_cnt++;
        prev_valid = bus.rx_valid;
        prev_data  = bus.rx_data;
      end
    join_none

    tick(3);
    chk("reset_rx_data", 64'(bus.rx_data), 64'd0);
    rst_n = 1'b1;
    tick(4);

    // Single frame, 4-cycle commit latency, one valid cycle
    bus.rx_ready = 1'b1;
    b = pop_log.size(); vb = valid_cnt; fb = ferr_cnt; ob = ovf_cnt;
    send_frame(64'hA5C31F, 24, 0);
    tick(12);
    chk("t1_pops", 64'(pop_log.size() - b), 64'd1);
    chk("t1_word", 64'(pop_log[b]), 64'hA5C31F);
    chk("t1_latency", 64'(pop_cyc[b] - t_cs), 64'd4);
    chk("t1_valid_cycles", 64'(valid_cnt - vb), 64'd1);
    chk("t1_no_err", 64'(ferr_cnt - fb + ovf_cnt - ob), 64'd0);

    // Five frames into a 4-deep FIFO, then drain
    bus.rx_ready = 1'b0;
    ob = ovf_cnt;
    for (int k = 1; k <= 5; k++) begin
      send_frame(64'(k), 24, 0);
      tick(8);
    end
    chk("t2_overflow_once", 64'(ovf_cnt - ob), 64'd1);
    chk("t2_head", 64'(bus.rx_data), 64'h000001);
    b = pop_log.size();
    bus.rx_ready = 1'b1;
    tick(8);
    chk("t2_pops", 64'(pop_log.size() - b), 64'd4);
    for (int k = 0; k < 4; k++) chk("t2_order", 64'(pop_log[b + k]), 64'(k + 1));
    chk("t2_back_to_back", 64'(pop_cyc[b + 3] - pop_cyc[b]), 64'd3);

    // 20-bit frame
    b = pop_log.size(); fb = ferr_cnt;
    send_frame(64'hFFFFF, 20, 0);
    tick(12);
`ifdef SPI_RX_LENGTH_CHECK_EN
    chk("t3_frame_err", 64'(ferr_cnt - fb), 64'd1);
    chk("t3_no_word", 64'(pop_log.size() - b), 64'd0);
`else
    chk("t3_frame_err", 64'(ferr_cnt - fb), 64'd0);
    chk("t3_word", 64'(pop_log[b]), 64'h0FFFFF);
`endif

    // Chip select pulse without clock edges
    b = pop_log.size(); fb = ferr_cnt; vb = valid_cnt;
    send_frame(64'd0, 0, 0);
    tick(12);
    chk("t4_no_push", 64'(valid_cnt - vb), 64'd0);
    chk("t4_no_err", 64'(ferr_cnt - fb), 64'd0);

    // Full FIFO with a pop in the commit cycle
    bus.rx_ready = 1'b0;
    ob = ovf_cnt; b = pop_log.size();
    for (int k = 1; k <= 4; k++) begin
      send_frame(64'(k * 17), 24, 0);
      tick(8);
    end
    send_frame(64'h123456, 24, 0);
    tick(3);
    bus.rx_ready = 1'b1;
    tick(1);
    bus.rx_ready = 1'b0;
    tick(6);
    chk("t5_no_overflow", 64'(ovf_cnt - ob), 64'd0);
    bus.rx_ready = 1'b1;
    tick(8);
    chk("t5_pops", 64'(pop_log.size() - b), 64'd5);
    chk("t5_w0", 64'(pop_log[b]), 64'h11);
    chk("t5_w1", 64'(pop_log[b + 1]), 64'h22);
    chk("t5_w2", 64'(pop_log[b + 2]), 64'h33);
    chk("t5_w3", 64'(pop_log[b + 3]), 64'h44);
    chk("t5_new", 64'(pop_log[b + 4]), 64'h123456);

    // Reset in the middle of a frame
    bus.rx_ready = 1'b0;
    send_frame(64'h777, 24, 0);
    tick(8);
    chk("t6_pre_valid", 64'(bus.rx_valid), 64'd1);
    fb = ferr_cnt;
    send_frame(64'hABC123, 24, 12);
    tick(12);
`ifdef SPI_RX_LENGTH_CHECK_EN
    chk("t6_frame_err", 64'(ferr_cnt - fb), 64'd1);
    chk("t6_no_valid", 64'(bus.rx_valid), 64'd0);
`else
    chk("t6_frame_err", 64'(ferr_cnt - fb), 64'd0);
    chk("t6_partial", 64'(bus.rx_data), 64'h000123);
`endif
    bus.rx_ready = 1'b1;
    send_frame(64'hABCDEF, 24, 0);
    tick(12);
    chk("t6_next_frame", 64'(pop_log[pop_log.size() - 1]), 64'hABCDEF);

    // Randomized frames and consumer backpressure
    rand_ready = 1'b1;
    for (int k = 0; k < 40; k++) begin
      int sel, n;
      sel = int'($urandom_range(0, 9));
      if (sel == 6)      n = 0;
      else if (sel == 7) n = int'($urandom_range(1, FB - 1));
      else if (sel == 8) n = int'($urandom_range(FB + 1, 30));
      else               n = int'(FB);
      send_frame({$urandom, $urandom}, n, 0);
      tick(int'($urandom_range(6, 15)));
    end
    rand_ready   = 1'b0;
    bus.rx_ready = 1'b1;
    tick(20);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/spi_frame_receiver.md
# spi_frame_receiver

Receive-side SPI endpoint for the controller's 24-bit command link. Captures MSB-first frames from an SPI master (clock idles high, data launched on falling edge, sampled here on rising edge) inside the system `clk` domain by oversampling. Each completed frame is validated and queued in a small FIFO, then delivered to downstream register/IRS-element logic over a valid/ready handshake.

## Interface
- `FRAME_BITS`, 24: bits per frame; `rx_data` width.
- `SYNC_STAGES`, 2: synchronizer flops on each SPI input (≥2).
- `FIFO_DEPTH`, 4: output queue entries (power of 2, ≥2).

- `clk`  in  1  system clock; must be ≥ 8× `spi_clock` frequency (100 MHz vs 10 MHz max).
- `rst_n`  in  1  reset, asynchronous, active-low.
- `spi_clock`  in  1  SPI clock from master, idles high.
- `spi_data`  in  1  serial data, MSB first.
- `cs_n`  in  1  chip select, active-low, frames the transfer.
- `rx_data`  out  FRAME_BITS  head-of-FIFO frame word.
- `rx_valid`  out  1  FIFO non-empty; `rx_data` valid.
- `rx_ready`  in  1  consumer accepts head word when `rx_valid`.
- `frame_err`  out  1  one-cycle pulse: frame discarded for wrong length.
- `overflow`  out  1  one-cycle pulse: valid frame dropped, FIFO full.
- `busy`  out  1  high while a frame is being received (synced `cs_n` low).

## Operation
- All three SPI inputs pass through `SYNC_STAGES` flops; synced `spi_clock` and `cs_n` keep one extra history flop for edge detection. Synchronizers reset to 1 (idle levels).
- FSM states: IDLE, SHIFT, COMMIT.
  - IDLE: waits for synced `cs_n` low → clears shift register and `bit_cnt`, enters SHIFT.
  - SHIFT: on each synced `spi_clock` rising edge, `shreg <= {shreg[FRAME_BITS-2:0], spi_data_s}`, `bit_cnt` increments, saturating at FRAME_BITS+1. Synced `cs_n` rising → COMMIT.
  - COMMIT (one cycle): evaluates the frame, returns to IDLE.
- Frame evaluation in COMMIT:
  - `bit_cnt == 0`: ignored silently, no pulse.
  - `bit_cnt == FRAME_BITS`: pushed to FIFO; if FIFO full and no pop this cycle, frame dropped and `overflow` pulses.
  - Other counts: length-check behaviour (see Configuration).
- FIFO: read/write pointers one bit wider than `log2(FIFO_DEPTH)`. Full = MSBs differ, rest equal; empty = equal. Pop when `rx_valid && rx_ready`. Push and pop in the same cycle while full both succeed (no overflow). Push and pop while empty: push only (a pop requires `rx_valid`).
- `rx_data` is the FIFO head and is stable while `rx_valid && !rx_ready`.
- SPI edges while synced `cs_n` is high are ignored. A `cs_n` high glitch shorter than one `clk` period may be missed; this is acceptable.
- Reset mid-frame: FSM goes to IDLE and FIFO empties. If `cs_n` is still low after reset release, the receiver enters SHIFT and captures only the remaining bits, which fails the length check.

## Timing
- Reset values: `rx_data`=0, `rx_valid`=0, `frame_err`=0, `overflow`=0, `busy`=0.
- Bit capture happens SYNC_STAGES+1 `clk` cycles after the `spi_clock` pin rising edge.
- Commit latency: COMMIT is the cycle after the synced `cs_n` rise. `rx_valid` rises on the next edge, i.e. SYNC_STAGES+2 `clk` edges after the first edge sampling `cs_n` high at the pin. With defaults this is 4 cycles.
- `frame_err` and `overflow` are asserted during the cycle after COMMIT, for exactly one cycle each.
- Back-to-back frames: minimum `cs_n` high time is SYNC_STAGES+3 `clk` cycles. This is met by the transmitter's 5-cycle `clk_div` gaps.

## Configuration
- `SPI_RX_LENGTH_CHECK_EN` defined: frames with `bit_cnt` ≠ FRAME_BITS (and ≠ 0) are discarded and `frame_err` pulses.
- Not defined: any frame with `bit_cnt` ≥ 1 is pushed. Short frames are right-justified with zero upper bits; long frames keep the last FRAME_BITS bits. `frame_err` is tied to 0.

## Test plan
- Single frame 0xA5C31F at sclk = clk/10, `rx_ready`=1 → `rx_valid` high for 1 cycle with `rx_data`=0xA5C31F, 4 clk after `cs_n` rise. No error pulses.
- Five frames 0x000001..0x000005 sent, `rx_ready`=0 throughout → FIFO holds 0x000001..0x000004 and `overflow` pulses once on the 5th. Then assert `rx_ready` → the four words drain in order, one per cycle.
- 20-bit frame (0xFFFFF), macro defined → `frame_err` one-cycle pulse, `rx_valid` stays 0. Macro undefined → `rx_data`=0x0FFFFF, no `frame_err`.
- `cs_n` low/high with no sclk edges → no push, no `frame_err`, FIFO unchanged.
- FIFO full with `rx_ready`=1 in the COMMIT cycle of a new frame 0x123456 → no `overflow`; 0x123456 is read out after the three older words.
- `rst_n` pulsed low at bit 12 of a frame → all outputs 0 asynchronously. The remaining 12 bits yield a `frame_err` (macro defined) and no valid word. The next full frame 0xABCDEF is received correctly.
